// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Pipelined branch resolution for the rv32i core. It evaluates the six branch
//   funct3 conditions on the EX operands, forms the taken target and the next
//   PC, and checks the outcome against the fetch-stage prediction. The results
//   travel through STAGES elastic valid/ready registers before they reach the
//   fetch redirect / ROB-commit consumer.
//
// Parameters
//   WIDTH   operand / PC width (>= 8)
//   STAGES  register stages between the input and the output (1..4)
//   TAG_W   width of the opaque tag carried alongside each branch
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready request handshake
//   rs1, rs2          compare operands
//   cmpop             branch funct3 (beq/bne/blt/bge/bltu/bgeu)
//   pc, imm           branch PC and sign-extended B-immediate
//   pred_taken        direction predicted at fetch
//   tag_in            tag passed through unchanged
//   kill              squash every in-flight entry and drop a concurrent input
//   out_valid/out_ready result handshake
//   br_en             branch taken
//   redirect_pc       br_en ? pc+imm : pc+4
//   mispredict        br_en != pred_taken, forced low while out_valid is low
//   illegal           cmpop is 3'b010 or 3'b011 (br_en forced low)
//   tag_out           tag of the presented result
//
// Optional feature: define BRANCH_STATS_EN to add the br_count and
// mispred_count outputs (32-bit wrapping counters of output handshakes and of
// mispredicted output handshakes).

module branch_resolve_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [2:0]       cmpop,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             pred_taken,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_en,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             mispredict,
  output logic             illegal,
  output logic [TAG_W-1:0] tag_out
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      br_count,
  output logic [31:0]      mispred_count
`endif
);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

  // ---------------------------------------------------------------------------
  // Combinational resolution on the incoming request
  // ---------------------------------------------------------------------------
  logic             cmp_eq;
  logic             cmp_lt_s;
  logic             cmp_lt_u;
  logic             take_d;
  logic             ill_d;
  logic [WIDTH-1:0] target_d;
  logic [WIDTH-1:0] seq_d;
  logic [WIDTH-1:0] rpc_d;
  logic             mis_d;

  assign cmp_eq   = (rs1 == rs2);
  assign cmp_lt_s = ($signed(rs1) < $signed(rs2));
  assign cmp_lt_u = (rs1 < rs2);

  always_comb begin
    take_d = 1'b0;
    ill_d  = 1'b0;
    case (cmpop)
      F3_BEQ:  take_d = cmp_eq;
      F3_BNE:  take_d = !cmp_eq;
      F3_BLT:  take_d = cmp_lt_s;
      F3_BGE:  take_d = !cmp_lt_s;
      F3_BLTU: take_d = cmp_lt_u;
      F3_BGEU: take_d = !cmp_lt_u;
      default: ill_d  = 1'b1;  // 3'b010 / 3'b011 are not branches
    endcase
  end

  // Both sums wrap modulo 2^WIDTH.
  assign target_d = pc + imm;
  assign seq_d    = pc + WIDTH'(4);
  assign rpc_d    = take_d ? target_d : seq_d;
  assign mis_d    = (take_d != pred_taken);

  // ---------------------------------------------------------------------------
  // Elastic stage registers
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] br_q;
  logic [STAGES-1:0] mis_q;
  logic [STAGES-1:0] ill_q;
  logic [WIDTH-1:0]  rpc_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];

  // rdy[i]: stage i may load this cycle. A stage can load when it, or any
  // stage downstream of it, is empty, or when the consumer is taking the
  // last stage. Built with a running OR so no signal feeds itself.
  logic [STAGES-1:0] rdy;

  always_comb begin
    logic chain;
    chain = out_ready;
    rdy   = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain  = chain || !v_q[i];
      rdy[i] = chain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      br_q  <= '0;
      mis_q <= '0;
      ill_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        rpc_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (kill) begin
      // Payload registers keep stale contents; only the valid bits matter.
      v_q <= '0;
    end else begin
      if (rdy[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          br_q[0]  <= take_d;
          mis_q[0] <= mis_d;
          ill_q[0] <= ill_d;
          rpc_q[0] <= rpc_d;
          tag_q[0] <= tag_in;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) begin
            br_q[i]  <= br_q[i-1];
            mis_q[i] <= mis_q[i-1];
            ill_q[i] <= ill_q[i-1];
            rpc_q[i] <= rpc_q[i-1];
            tag_q[i] <= tag_q[i-1];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready    = rdy[0];
  assign out_valid   = v_q[STAGES-1];
  assign br_en       = br_q[STAGES-1];
  assign illegal     = ill_q[STAGES-1];
  assign redirect_pc = rpc_q[STAGES-1];
  assign tag_out     = tag_q[STAGES-1];
  assign mispredict  = v_q[STAGES-1] && mis_q[STAGES-1];

`ifdef BRANCH_STATS_EN
  // Counts follow output handshakes only, so kill leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (out_valid && out_ready) begin
      br_count <= br_count + 32'd1;
      if (mispredict) begin
        mispred_count <= mispred_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  // Compare table: two operand patterns across all six conditions.
  localparam int NCMP = 12;
  localparam logic [31:0] T_RS1 [NCMP] = '{
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
    32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
  localparam logic [31:0] T_RS2 [NCMP] = '{
    32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1,
    32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
  localparam logic [2:0] T_OP [NCMP] = '{
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  // -1 vs 1: beq0 bne1 blt1 bge0 bltu0 bgeu1 ; equal: beq1 bne0 blt0 bge1 bltu0 bgeu1
  localparam logic T_EXP [NCMP] = '{
    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1, rs2, pc, imm;
  logic [2:0]       cmpop;
  logic             pred_taken;
  logic [TAG_W-1:0] tag_in;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic             br_en;
  logic [WIDTH-1:0] redirect_pc;
  logic             mispredict;
  logic             illegal;
  logic [TAG_W-1:0] tag_out;
`ifdef BRANCH_STATS_EN
  logic [31:0]      br_count;
  logic [31:0]      mispred_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .cmpop(cmpop), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .tag_in(tag_in), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready),
    .br_en(br_en), .redirect_pc(redirect_pc), .mispredict(mispredict),
    .illegal(illegal), .tag_out(tag_out)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .mispred_count(mispred_count)
`endif
  );

  // Drives one request at the current negedge; the caller picks in_valid.
  task automatic set_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] p, input logic [31:0] im, input logic pr,
                         input logic [TAG_W-1:0] t);
    rs1 = a; rs2 = b; cmpop = op; pc = p; imm = im; pred_taken = pr; tag_in = t;
  endtask

  // Request already set up with in_valid=1 on an empty pipeline and out_ready=1:
  // returns at the negedge where out_valid rises, with its latency in cycles.
  task automatic issue_and_wait(output int lat);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
    set_req(32'h0, 32'h0, OP_BEQ, 32'h0, 32'h0, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (br_en !== 1'b0) begin failures++; $display("FAIL reset_br_en got=%b exp=0", br_en); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL reset_mispredict got=%b exp=0", mispredict); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    checks++; if (tag_out !== 4'h0) begin failures++; $display("FAIL reset_tag_out got=%h exp=0", tag_out); end
  endtask

  task automatic test_compare();
    int lat;
    logic [31:0] exp_pc;
    out_ready = 1'b1;
    for (int i = 0; i < NCMP; i++) begin
      set_req(T_RS1[i], T_RS2[i], T_OP[i], 32'h0000_0100, 32'h0000_0020, 1'b1, TAG_W'(i));
      in_valid = 1'b1;
      issue_and_wait(lat);
      exp_pc = T_EXP[i] ? 32'h0000_0120 : 32'h0000_0104;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL cmp_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (br_en !== T_EXP[i]) begin failures++; $display("FAIL cmp_br_en[%0d] op=%b got=%b exp=%b", i, T_OP[i], br_en, T_EXP[i]); end
      checks++; if (redirect_pc !== exp_pc) begin failures++; $display("FAIL cmp_redirect[%0d] got=%h exp=%h", i, redirect_pc, exp_pc); end
      checks++; if (mispredict !== !T_EXP[i]) begin failures++; $display("FAIL cmp_mispredict[%0d] got=%b exp=%b", i, mispredict, !T_EXP[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_redirect();
    int lat;
    out_ready = 1'b1;
    set_req(32'h5, 32'h5, OP_BEQ, 32'h0000_1000, 32'hFFFF_FFF8, 1'b0, 4'hA);
    in_valid = 1'b1;
    issue_and_wait(lat);
    checks++; if (lat !== STAGES) begin failures++; $display("FAIL redirect_latency got=%0d exp=%0d", lat, STAGES); end
    checks++; if (br_en !== 1'b1) begin failures++; $display("FAIL redirect_br_en got=%b exp=1", br_en); end
    checks++; if (redirect_pc !== 32'h0000_0FF8) begin failures++; $display("FAIL redirect_pc got=%h exp=00000ff8", redirect_pc); end
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL redirect_mispredict got=%b exp=1", mispredict); end
    checks++; if (tag_out !== 4'hA) begin failures++; $display("FAIL redirect_tag got=%h exp=a", tag_out); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int lat;
    out_ready = 1'b1;
    set_req(32'h7, 32'h7, OP_BNE, 32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 4'h3);
    in_valid = 1'b1;
    issue_and_wait(lat);
    checks++; if (br_en !== 1'b0) begin failures++; $display("FAIL wrap_br_en got=%b exp=0", br_en); end
    checks++; if (redirect_pc !== 32'h0000_0000) begin failures++; $display("FAIL wrap_redirect got=%h exp=00000000", redirect_pc); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL wrap_mispredict got=%b exp=0", mispredict); end
    // Taken target wrapping past zero.
    set_req(32'h1, 32'h2, OP_BNE, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 4'h4);
    in_valid = 1'b1;
    issue_and_wait(lat);
    checks++; if (redirect_pc !== 32'h0000_0010) begin failures++; $display("FAIL wrap_target got=%h exp=00000010", redirect_pc); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int lat;
    out_ready = 1'b1;
    // Operands equal so a beq-like decode would wrongly take the branch.
    set_req(32'h9, 32'h9, 3'b010, 32'h0000_2000, 32'h0000_0040, 1'b1, 4'h6);
    in_valid = 1'b1;
    issue_and_wait(lat);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_010 got=%b exp=1", illegal); end
    checks++; if (br_en !== 1'b0) begin failures++; $display("FAIL illegal_br_en got=%b exp=0", br_en); end
    checks++; if (redirect_pc !== 32'h0000_2004) begin failures++; $display("FAIL illegal_redirect got=%h exp=00002004", redirect_pc); end
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL illegal_mispredict got=%b exp=1", mispredict); end
    set_req(32'h9, 32'h8, 3'b011, 32'h0000_2100, 32'h0000_0040, 1'b0, 4'h7);
    in_valid = 1'b1;
    issue_and_wait(lat);
    checks++; if (illegal !== 1'b1 || br_en !== 1'b0) begin failures++; $display("FAIL illegal_011 got ill=%b br=%b exp ill=1 br=0", illegal, br_en); end
    // A legal op right after must clear illegal.
    set_req(32'h9, 32'h9, OP_BEQ, 32'h0000_2200, 32'h0000_0040, 1'b0, 4'h8);
    in_valid = 1'b1;
    issue_and_wait(lat);
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_clear got=%b exp=0", illegal); end
    // Mispredicted result drained: mispredict must drop with out_valid.
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || mispredict !== 1'b0) begin failures++; $display("FAIL mispredict_gate got v=%b m=%b exp v=0 m=0", out_valid, mispredict); end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int first_c = -1;
    int last_c = -1;
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          set_req(32'h1, 32'h1, OP_BEQ, 32'h0000_4000, 32'h0000_0100, 1'b1, TAG_W'(k + 5));
          in_valid = 1'b1;
          #1;
          checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", k, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          #1;
          if (out_valid && got < 4) begin
            checks++; if (tag_out !== TAG_W'(got + 5)) begin failures++; $display("FAIL b2b_tag[%0d] got=%h exp=%h", got, tag_out, TAG_W'(got + 5)); end
            if (first_c < 0) first_c = c;
            last_c = c;
            got++;
          end
        end
      end
    join
    checks++; if (got !== 4 || (last_c - first_c) !== 3) begin failures++; $display("FAIL b2b_throughput got n=%0d span=%0d exp n=4 span=3", got, last_c - first_c); end
  endtask

  task automatic test_backpressure();
    int got = 0;
    int extra = 0;
    logic [31:0] base;
    logic        exp_br;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          int guard = 0;
          @(negedge clk);
          set_req(32'(k), (k % 2 == 0) ? 32'(k) : 32'hDEAD, OP_BEQ,
                  32'h0000_3000 + 32'(k * 16), 32'h0000_0008, 1'b0, TAG_W'(k));
          in_valid = 1'b1;
          #1;
          if (k == 2) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
          end
          while (!in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 60 && got < 5; c++) begin
          @(negedge clk);
          out_ready = (c >= 3);
          #1;
          if (out_valid && out_ready) begin
            base   = 32'h0000_3000 + 32'(got * 16);
            exp_br = (got % 2 == 0);
            checks++; if (tag_out !== TAG_W'(got)) begin failures++; $display("FAIL bp_tag[%0d] got=%h exp=%h", got, tag_out, TAG_W'(got)); end
            checks++; if (br_en !== exp_br) begin failures++; $display("FAIL bp_br_en[%0d] got=%b exp=%b", got, br_en, exp_br); end
            checks++; if (redirect_pc !== (exp_br ? base + 32'h8 : base + 32'h4)) begin failures++; $display("FAIL bp_redirect[%0d] got=%h exp=%h", got, redirect_pc, exp_br ? base + 32'h8 : base + 32'h4); end
            got++;
          end
        end
      end
    join
    checks++; if (got !== 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", got); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL bp_duplicate got=%0d extra outputs exp=0", extra); end
  endtask

  task automatic test_kill();
    int seen = 0;
    out_ready = 1'b0;
    @(negedge clk);
    set_req(32'h1, 32'h1, OP_BEQ, 32'h0000_5000, 32'h4, 1'b0, 4'h1);
    in_valid = 1'b1;
    @(negedge clk);
    set_req(32'h1, 32'h1, OP_BEQ, 32'h0000_5010, 32'h4, 1'b0, 4'h2);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL kill_setup_full got=%b exp=1", out_valid); end
    set_req(32'h1, 32'h1, OP_BEQ, 32'h0000_5020, 32'h4, 1'b0, 4'h3);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL kill_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL kill_in_ready got=%b exp=1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL kill_leak got=%0d outputs exp=0", seen); end
    // Kill on an empty pipeline while an input would otherwise be accepted.
    seen = 0;
    set_req(32'h2, 32'h2, OP_BEQ, 32'h0000_6000, 32'h4, 1'b0, 4'h9);
    in_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL kill_drop_input got=%0d outputs exp=0", seen); end
  endtask

  task automatic test_reset_midstream();
    int guard = 0;
    out_ready = 1'b0;
    set_req(32'h3, 32'h3, OP_BEQ, 32'h0000_7000, 32'h0000_0100, 1'b0, 4'hB);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (redirect_pc !== 32'h0000_7100 || out_valid !== 1'b1) begin failures++; $display("FAIL midrst_setup got v=%b pc=%h exp v=1 pc=00007100", out_valid, redirect_pc); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (br_en !== 1'b0 || redirect_pc !== 32'h0 || tag_out !== 4'h0) begin failures++; $display("FAIL midrst_outputs got br=%b pc=%h tag=%h exp all 0", br_en, redirect_pc, tag_out); end
    out_ready = 1'b1;
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    int lat;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (br_count !== 32'd0 || mispred_count !== 32'd0) begin failures++; $display("FAIL stats_reset got br=%0d mis=%0d exp 0 0", br_count, mispred_count); end
    out_ready = 1'b1;
    set_req(32'h1, 32'h1, OP_BEQ, 32'h100, 32'h8, 1'b1, 4'h1);
    in_valid = 1'b1; issue_and_wait(lat);
    set_req(32'h1, 32'h2, OP_BEQ, 32'h200, 32'h8, 1'b1, 4'h2);
    in_valid = 1'b1; issue_and_wait(lat);
    set_req(32'h1, 32'h2, OP_BNE, 32'h300, 32'h8, 1'b1, 4'h3);
    in_valid = 1'b1; issue_and_wait(lat);
    @(negedge clk);
    checks++; if (br_count !== 32'd3) begin failures++; $display("FAIL stats_br_count got=%0d exp=3", br_count); end
    checks++; if (mispred_count !== 32'd1) begin failures++; $display("FAIL stats_mispred_count got=%0d exp=1", mispred_count); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_compare();
    test_redirect();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_kill();
    test_reset_midstream();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
